// File: rtl/fp_vec_add_arbiter_if.sv
// Bundles the two requester ports, the shared adder port and the response/status
// signals of fp_vec_add_arbiter. master = arbiter side, slave = environment side.
interface fp_vec_add_arbiter_if #(
    parameter int W  = 12,
    parameter int CW = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [4*W-1:0]  req0_x;
    logic [4*W-1:0]  req0_y;
    logic            req1_valid;
    logic            req1_ready;
    logic [4*W-1:0]  req1_x;
    logic [4*W-1:0]  req1_y;
    logic            add_in_valid;
    logic [4*W-1:0]  add_x;
    logic [4*W-1:0]  add_y;
    logic            add_out_valid;
    logic [4*W-1:0]  add_sum;
    logic            rsp0_valid;
    logic            rsp1_valid;
    logic [4*W-1:0]  rsp_sum;
    logic [CW-1:0]   inflight;
    logic            tag_err;

    modport master (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
               add_out_valid, add_sum,
        output req0_ready, req1_ready, add_in_valid, add_x, add_y,
               rsp0_valid, rsp1_valid, rsp_sum, inflight, tag_err
    );

    modport slave (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
               add_out_valid, add_sum,
        input  req0_ready, req1_ready, add_in_valid, add_x, add_y,
               rsp0_valid, rsp1_valid, rsp_sum, inflight, tag_err
    );
endinterface

// File: rtl/fp_vec_add_arbiter.sv
// Round-robin sharing of one non-stalling 4-lane FP vector adder between two
// requesters, with a credit limit and a tag FIFO that routes results back in order.
module fp_vec_add_arbiter #(
    parameter int EXP_BITS  = 5,
    parameter int MANT_BITS = 6,
    parameter int DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_vec_add_arbiter_if.master  bus
);
    localparam int W  = EXP_BITS + MANT_BITS + 1;
    localparam int VW = 4 * W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    inflight_q, inflight_d;
    logic             last_grant_q, last_grant_d;   // 1 = requester 1 won last
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] tag_q, tag_d;                 // owner id per in-flight slot
    logic             add_in_valid_q, add_in_valid_d;
    logic [VW-1:0]    add_x_q, add_x_d;
    logic [VW-1:0]    add_y_q, add_y_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [VW-1:0]    rsp_sum_q, rsp_sum_d;
    logic             tag_err_q, tag_err_d;

    logic can_issue, grant0, grant1, push, pop, fifo_empty, head;

    always_comb begin
        // The credit check looks only at the registered count, so a same-cycle
        // pop never opens a slot early.
        can_issue  = inflight_q < CW'(DEPTH);
        grant0     = can_issue && bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1     = can_issue && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        push       = grant0 || grant1;
        fifo_empty = (inflight_q == '0);
        pop        = bus.add_out_valid && !fifo_empty;
        head       = tag_q[rd_ptr_q];

        last_grant_d   = last_grant_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        tag_d          = tag_q;
        add_x_d        = add_x_q;
        add_y_d        = add_y_q;
        rsp_sum_d      = rsp_sum_q;
        add_in_valid_d = push;
        rsp0_valid_d   = pop && !head;
        rsp1_valid_d   = pop && head;
        inflight_d     = inflight_q + CW'(push) - CW'(pop);
        tag_err_d      = tag_err_q || (bus.add_out_valid && fifo_empty);

        if (push) begin
            last_grant_d    = grant1;
            tag_d[wr_ptr_q] = grant1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            add_x_d         = grant1 ? bus.req1_x : bus.req0_x;
            add_y_d         = grant1 ? bus.req1_y : bus.req0_y;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rsp_sum_d = bus.add_sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q     <= '0;
            last_grant_q   <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            tag_q          <= '0;
            add_in_valid_q <= 1'b0;
            add_x_q        <= '0;
            add_y_q        <= '0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp_sum_q      <= '0;
            tag_err_q      <= 1'b0;
        end else begin
            inflight_q     <= inflight_d;
            last_grant_q   <= last_grant_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            tag_q          <= tag_d;
            add_in_valid_q <= add_in_valid_d;
            add_x_q        <= add_x_d;
            add_y_q        <= add_y_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp_sum_q      <= rsp_sum_d;
            tag_err_q      <= tag_err_d;
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.add_in_valid = add_in_valid_q;
    assign bus.add_x        = add_x_q;
    assign bus.add_y        = add_y_q;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp_sum      = rsp_sum_q;
    assign bus.inflight     = inflight_q;
    assign bus.tag_err      = tag_err_q;
endmodule

// File: tb/tb_fp_vec_add_arbiter.sv
// Randomized bench for fp_vec_add_arbiter: a stub adder with run-time latency and
// a timestamp-based reference model that predicts every output each cycle.
module tb_fp_vec_add_arbiter;
    localparam int DEPTH = 8;
    localparam int VW    = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_vec_add_arbiter_if #(.W(12), .CW(4)) bus ();

    fp_vec_add_arbiter #(.EXP_BITS(5), .MANT_BITS(6), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stub adder: lane-agnostic 48-bit sum, latency L (1..16), flushed by reset.
    int L = 3;
    logic spur = 1'b0;
    logic [15:0]   sv;
    logic [VW-1:0] ss [16];
    always @(posedge clk or negedge rst) begin
        if (!rst) sv <= '0;
        else      sv <= {sv[14:0], bus.add_in_valid};
    end
    always @(posedge clk) begin
        ss[0] <= bus.add_x + bus.add_y;
        for (int i = 1; i < 16; i++) ss[i] <= ss[i-1];
    end
    assign bus.add_out_valid = sv[L-1] | spur;
    assign bus.add_sum       = ss[L-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: each accepted op remembers its grant cycle and latency.
    typedef struct {
        int          t;
        bit          id;
        logic [VW-1:0] s;
        int          l;
    } op_t;
    op_t q[$];
    bit            mlast = 1'b1;
    bit            livalid = 1'b0;
    logic [VW-1:0] lx = '0, ly = '0;
    bit            mterr = 1'b0;
    bit            mg0 = 1'b0, mg1 = 1'b0;

    function automatic int m_inflight();
        int n = 0;
        foreach (q[i]) if (q[i].t + 1 <= cyc && cyc <= q[i].t + 1 + q[i].l) n++;
        return n;
    endfunction

    function automatic void m_grant(output bit g0, output bit g1);
        bit ci;
        ci = (m_inflight() < DEPTH);
        g0 = ci && bus.req0_valid && (!bus.req1_valid || mlast);
        g1 = ci && bus.req1_valid && (!bus.req0_valid || !mlast);
    endfunction

    bit pg0, pg1;
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            mlast = 1'b1; livalid = 1'b0; lx = '0; ly = '0;
            mterr = 1'b0; mg0 = 1'b0; mg1 = 1'b0;
        end else begin
            m_grant(pg0, pg1);
            if (spur && m_inflight() == 0) mterr = 1'b1;
            mg0 = pg0; mg1 = pg1;
            livalid = pg0 || pg1;
            if (pg0 || pg1) begin
                lx = pg1 ? bus.req1_x : bus.req0_x;
                ly = pg1 ? bus.req1_y : bus.req0_y;
                q.push_back('{t: cyc, id: pg1, s: lx + ly, l: L});
                mlast = pg1;
            end
            while (q.size() > 0 && q[0].t + 2 + q[0].l <= cyc) void'(q.pop_front());
            cyc++;
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    bit cg0, cg1, e0, e1;
    logic [VW-1:0] es;
    always @(negedge clk) begin
        if (rst) begin
            m_grant(cg0, cg1);
            chk("req0_ready", bus.req0_ready, cg0);
            chk("req1_ready", bus.req1_ready, cg1);
            chk("add_in_valid", bus.add_in_valid, livalid);
            chk("add_x", bus.add_x, lx);
            chk("add_y", bus.add_y, ly);
            chk("inflight", bus.inflight, m_inflight());
            chk("tag_err", bus.tag_err, mterr);
            e0 = 1'b0; e1 = 1'b0; es = '0;
            foreach (q[i]) if (q[i].t + 2 + q[i].l == cyc) begin
                e0 = !q[i].id; e1 = q[i].id; es = q[i].s;
            end
            chk("rsp0_valid", bus.rsp0_valid, e0);
            chk("rsp1_valid", bus.rsp1_valid, e1);
            if (e0 || e1) chk("rsp_sum", bus.rsp_sum, es);
        end
    end

    // Stimulus: mode 0 manual, 1 random, 2 both always valid (y=0), 3 req1 only.
    int mode = 0;

    function automatic logic [VW-1:0] rnd48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    task automatic update_inputs();
        if (mg0) bus.req0_valid = 1'b0;
        if (mg1) bus.req1_valid = 1'b0;
        if ((mode == 1 && $urandom_range(0, 2) != 0) || mode == 2) begin
            if (!bus.req0_valid) begin
                bus.req0_valid = 1'b1;
                bus.req0_x = rnd48();
                bus.req0_y = (mode == 2) ? '0 : rnd48();
            end
        end
        if ((mode == 1 && $urandom_range(0, 2) != 0) || mode == 2 || mode == 3) begin
            if (!bus.req1_valid) begin
                bus.req1_valid = 1'b1;
                bus.req1_x = rnd48();
                bus.req1_y = (mode == 2) ? '0 : rnd48();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_inputs();
    endtask

    task automatic idle(input int n);
        mode = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, bus.req0_ready, 0);
        chk({tag, "_ready1"}, bus.req1_ready, 0);
        chk({tag, "_in_valid"}, bus.add_in_valid, 0);
        chk({tag, "_add_x"}, bus.add_x, 0);
        chk({tag, "_add_y"}, bus.add_y, 0);
        chk({tag, "_rsp0"}, bus.rsp0_valid, 0);
        chk({tag, "_rsp1"}, bus.rsp1_valid, 0);
        chk({tag, "_rsp_sum"}, bus.rsp_sum, 0);
        chk({tag, "_inflight"}, bus.inflight, 0);
        chk({tag, "_tag_err"}, bus.tag_err, 0);
    endtask

    task automatic do_reset(input string tag);
        mode = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        spur = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero(tag);
        tick();
        tick();
        rst = 1'b1;
    endtask

    int grants, maxinf, n1;
    bit seen;

    initial begin
        bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
        bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
        tick();
        tick();
        chk_all_zero("por");
        rst = 1'b1;
        tick();

        // Single op: literal operands and literal lane-wise sum 0x424 + 0x3F4 = 0x818.
        bus.req0_valid = 1'b1;
        bus.req0_x = {4{12'b0_10000_100100}};
        bus.req0_y = {4{12'b0_01111_110100}};
        @(negedge clk);
        chk("single_ready0", bus.req0_ready, 1);
        tick();
        @(negedge clk);
        chk("single_in_valid", bus.add_in_valid, 1);
        chk("single_add_x", bus.add_x, 48'h424424424424);
        chk("single_add_y", bus.add_y, 48'h3F43F43F43F4);
        repeat (4) tick();
        @(negedge clk);
        chk("single_rsp0", bus.rsp0_valid, 1);
        chk("single_rsp1", bus.rsp1_valid, 0);
        chk("single_sum", bus.rsp_sum, 48'h818818818818);
        tick();
        @(negedge clk);
        chk("single_inflight0", bus.inflight, 0);

        // Contention right after reset: grant order 0,1,0,1.
        do_reset("rst1");
        mode = 2;
        update_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("cont_ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        idle(15);

        // Credit limit: latency 12 > DEPTH, so exactly DEPTH grants precede the first result.
        do_reset("rst2");
        L = 12;
        mode = 2;
        update_inputs();
        grants = 0; seen = 1'b0; maxinf = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.add_out_valid) seen = 1'b1;
            else begin
                grants += int'(bus.req0_ready) + int'(bus.req1_ready);
                tick();
            end
        end
        chk("credit_seen_result", seen, 1);
        chk("credit_grants", grants, DEPTH);
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (int'(bus.inflight) > maxinf) maxinf = int'(bus.inflight);
        end
        chk("credit_max_inflight", maxinf, DEPTH);
        idle(25);
        L = 3;
        idle(5);

        // Spurious result with nothing in flight.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        @(negedge clk);
        chk("spur_tag_err", bus.tag_err, 1);
        chk("spur_rsp0", bus.rsp0_valid, 0);
        chk("spur_rsp1", bus.rsp1_valid, 0);
        chk("spur_inflight", bus.inflight, 0);
        idle(5);
        @(negedge clk);
        chk("spur_sticky", bus.tag_err, 1);

        // Reset with three ops in flight: no responses afterwards, req0 wins next.
        tick();
        mode = 2;
        update_inputs();
        repeat (3) tick();
        do_reset("rst3");
        idle(10);
        mode = 2;
        update_inputs();
        @(negedge clk);
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        tick();
        idle(15);

        // Back-to-back single requester: ready every cycle, ten responses.
        mode = 3;
        update_inputs();
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b2b_ready1", bus.req1_ready, 1);
            if (bus.rsp1_valid) n1++;
            if (i == 9) mode = 0;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp1_valid) n1++;
            tick();
        end
        chk("b2b_rsp1_count", n1, 10);

        // Random traffic, short then credit-bound latency.
        mode = 1;
        update_inputs();
        repeat (400) tick();
        idle(25);
        L = 10;
        mode = 1;
        update_inputs();
        repeat (300) tick();
        idle(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
